i2c_master_arbiter: RTL
=======================

Name: i2c_master_arbiter

Overview:
Shares the single i2c_master between NUM_REQ independent requesters, for example the UART command path (i2c_ctrl) and an on-chip sensor poller. It arbitrates round-robin and latches the winner's command onto the master's command inputs. It routes per-byte write-ack and read-data strobes back to the granted requester only. A watchdog covers transfers that never start or never finish.

Parameters:
NUM_REQ, 2, number of requesters (2..8)
DATA_WIDTH, 8, I2C data byte width
ADDR_WIDTH, 7, I2C device address width
NBYTE_WIDTH, 8, byte-count width
TIMEOUT_CYCLES, 1000000, watchdog limit in clk cycles (20 ms at 50 MHz)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
req_valid  in  NUM_REQ  request per requester; held until its done pulse
req_rw  in  NUM_REQ  1 = read, 0 = write
req_addr  in  NUM_REQ*ADDR_WIDTH  flattened device addresses
req_num_byte  in  NUM_REQ*NBYTE_WIDTH  flattened byte counts
req_wdata  in  NUM_REQ*DATA_WIDTH  flattened current write byte
wdata_ack  out  NUM_REQ  one-cycle pulse: present next write byte
rdata  out  DATA_WIDTH  read byte, shared by all requesters
rdata_valid  out  NUM_REQ  one-cycle pulse: rdata valid for this requester
done  out  NUM_REQ  one-cycle completion pulse
err  out  NUM_REQ  one-cycle error pulse, coincident with done
grant_id  out  $clog2(NUM_REQ)  index of current or last owner
m_enable  out  1  to i2c_master i_enable
m_rw  out  1  to i_rw
m_mosi_data  out  DATA_WIDTH  to i_mosi_data
m_device_addr  out  ADDR_WIDTH  to i_device_addr
m_num_byte  out  NBYTE_WIDTH  to i_num_byte
m_miso_data  in  DATA_WIDTH  from o_miso_data
m_en_ack  in  1  from o_en_ack
m_data_valid  in  1  from o_data_valid_out
m_busy  in  1  from o_busy

Behaviour:
- Reset (asynchronous, rst_n low):
  - All outputs are 0.
  - State is IDLE.
  - Round-robin pointer is NUM_REQ-1, so requester 0 wins first after reset.
  - Watchdog and byte counter are 0.
- States: IDLE, LAUNCH, XFER, FINISH.
- IDLE: when any req_valid is high and m_busy is low at edge t:
  - The rr_arbiter picks the first requester after the pointer.
  - Its rw, addr, num_byte and index are registered at t.
  - State goes to LAUNCH, with m_enable high from t+1.
  - If m_busy is high, wait. No request is lost.
- Zero-length request (num_byte == 0): from IDLE go straight to FINISH with err set. The master is never enabled.
- LAUNCH: m_enable is held high until m_busy is sampled high, then state goes to XFER. m_enable is low from the following cycle.
- XFER:
  - m_mosi_data = req_wdata slice of grant_id, combinational.
  - m_en_ack high → wdata_ack[grant_id] high on the next cycle (registered).
  - m_data_valid high → rdata <= m_miso_data and rdata_valid[grant_id] high on the next cycle.
  - Strobes never reach a non-granted requester.
  - Byte counter increments on each en_ack (write) or data_valid (read). Strobes past num_byte are forwarded; no error is raised.
  - m_busy sampled low → FINISH.
- FINISH (one cycle):
  - done[grant_id] pulses, plus err[grant_id] if an error is flagged.
  - Pointer <= grant_id.
  - Next state is IDLE. Re-arbitration is possible the cycle after FINISH.
  - Worst-case wait for a continuously requesting source is NUM_REQ-1 transfers.
- Watchdog:
  - Counts cycles in LAUNCH and XFER and clears on each state entry.
  - Reaching TIMEOUT_CYCLES-1 → FINISH with err set, and m_enable is forced low.
  - The master itself is not reset. Arbitration re-waits for m_busy low in IDLE.
- req_valid dropped mid-transfer: ignored. The transfer completes and done still pulses.
- Simultaneous m_en_ack and m_busy falling: the strobe is forwarded, then FINISH.
- m_rw, m_device_addr and m_num_byte stay stable from LAUNCH through FINISH.

Decomposition:
- Package i2c_arb_pkg holds:
  - the state enum
  - default DATA_WIDTH, ADDR_WIDTH and NBYTE_WIDTH constants
  - the TIMEOUT_CYCLES default
- Sub-module rr_arbiter: combinational one-hot round-robin picker.
  - Inputs: req[NUM_REQ] and the pointer.
  - Outputs: a grant index and any_req.
  - Reused by later shared-resource arbiters.

Test Plan:
- Reset priority: req0 and req1 both request a write of 2 bytes, addr 0x50, simultaneously after reset → req0 granted first. m_enable rises 1 cycle after request, two wdata_ack[0] pulses, done[0], then req1 serviced. wdata_ack[1] and rdata_valid[1] stay 0 during req0's transfer.
- Fairness: both requesters assert continuously for 6 transfers → grants alternate 0,1,0,1,0,1.
- Read routing: req1 reads 3 bytes; model returns 0xA5, 0x5A, 0x3C → rdata_valid[1] pulses three times with those values. rdata_valid[0] stays 0.
- Zero length: req0 with num_byte = 0 → done[0] and err[0] within 2 cycles; m_enable never asserted.
- Timeout: TIMEOUT_CYCLES = 100 and the model never raises m_busy → err[0] and done[0] exactly 100 cycles after LAUNCH entry; m_enable low afterwards.
- Reset mid-XFER: rst_n low during byte 2 of a read → all outputs 0 immediately. After release, the next grant goes to requester 0.

Source files
------------

// File: rtl/i2c_arb_pkg.sv
// Shared constants and FSM encoding for the i2c_master arbiter.
// Reused by rr_arbiter and i2c_master_arbiter.
package i2c_arb_pkg;

  localparam int unsigned DEF_DATA_WIDTH     = 8;
  localparam int unsigned DEF_ADDR_WIDTH     = 7;
  localparam int unsigned DEF_NBYTE_WIDTH    = 8;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 1000000;

  typedef logic [1:0] arb_state_t;

  localparam arb_state_t ST_IDLE   = 2'd0;
  localparam arb_state_t ST_LAUNCH = 2'd1;
  localparam arb_state_t ST_XFER   = 2'd2;
  localparam arb_state_t ST_FINISH = 2'd3;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: grants the first requester after ptr.
// The requester at ptr itself has the lowest priority.
module rr_arbiter
  import i2c_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2,
  localparam int unsigned IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDW-1:0]     ptr,
  output logic [IDW-1:0]     grant,
  output logic               any_req
);

  logic [IDW-1:0] cand [NUM_REQ];

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      cand[i] = IDW'((int'(ptr) + i + 1) % NUM_REQ);
    end
  end

  // Walk from the farthest candidate down so the nearest active one wins.
  always_comb begin
    grant   = '0;
    any_req = |req;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[cand[i]]) begin
        grant = cand[i];
      end
    end
  end

endmodule

// File: rtl/i2c_master_arbiter.sv
// Shares one i2c_master between NUM_REQ requesters with round-robin
// arbitration, per-requester strobe routing and a transfer watchdog.
module i2c_master_arbiter
  import i2c_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ        = 2,
  parameter int unsigned DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH     = DEF_ADDR_WIDTH,
  parameter int unsigned NBYTE_WIDTH    = DEF_NBYTE_WIDTH,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  localparam int unsigned IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ-1:0]             req_rw,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]  req_addr,
  input  logic [NUM_REQ*NBYTE_WIDTH-1:0] req_num_byte,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_wdata,
  output logic [NUM_REQ-1:0]             wdata_ack,
  output logic [DATA_WIDTH-1:0]          rdata,
  output logic [NUM_REQ-1:0]             rdata_valid,
  output logic [NUM_REQ-1:0]             done,
  output logic [NUM_REQ-1:0]             err,
  output logic [IDW-1:0]                 grant_id,
  output logic                           m_enable,
  output logic                           m_rw,
  output logic [DATA_WIDTH-1:0]          m_mosi_data,
  output logic [ADDR_WIDTH-1:0]          m_device_addr,
  output logic [NBYTE_WIDTH-1:0]         m_num_byte,
  input  logic [DATA_WIDTH-1:0]          m_miso_data,
  input  logic                           m_en_ack,
  input  logic                           m_data_valid,
  input  logic                           m_busy
);

  localparam int unsigned WDW = $clog2(TIMEOUT_CYCLES) + 1;

  arb_state_t state_q, state_d;
  logic [IDW-1:0]         ptr_q, ptr_d;
  logic [IDW-1:0]         grant_q, grant_d;
  logic                   rw_q, rw_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [NBYTE_WIDTH-1:0] nbyte_q, nbyte_d;
  logic [NBYTE_WIDTH-1:0] bcnt_q, bcnt_d;
  logic [WDW-1:0]         wd_q, wd_d;
  logic                   en_q, en_d;
  logic [DATA_WIDTH-1:0]  rdata_q, rdata_d;
  logic [NUM_REQ-1:0]     wack_q, wack_d;
  logic [NUM_REQ-1:0]     rvld_q, rvld_d;
  logic [NUM_REQ-1:0]     done_q, done_d;
  logic [NUM_REQ-1:0]     err_q, err_d;

  logic [IDW-1:0] arb_idx;
  logic           arb_any;
  logic           wd_expired;

  logic [ADDR_WIDTH-1:0]  addr_arr  [NUM_REQ];
  logic [NBYTE_WIDTH-1:0] nbyte_arr [NUM_REQ];
  logic [DATA_WIDTH-1:0]  wdata_arr [NUM_REQ];

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      addr_arr[i]  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
      nbyte_arr[i] = req_num_byte[i*NBYTE_WIDTH +: NBYTE_WIDTH];
      wdata_arr[i] = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_arbiter (
    .req     (req_valid),
    .ptr     (ptr_q),
    .grant   (arb_idx),
    .any_req (arb_any)
  );

  assign wd_expired = (wd_q == WDW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    rw_d    = rw_q;
    addr_d  = addr_q;
    nbyte_d = nbyte_q;
    bcnt_d  = bcnt_q;
    wd_d    = wd_q;
    en_d    = en_q;
    rdata_d = rdata_q;
    wack_d  = '0;
    rvld_d  = '0;
    done_d  = '0;
    err_d   = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (arb_any && !m_busy) begin
          grant_d = arb_idx;
          rw_d    = req_rw[arb_idx];
          addr_d  = addr_arr[arb_idx];
          nbyte_d = nbyte_arr[arb_idx];
          bcnt_d  = '0;
          wd_d    = '0;
          // A zero-length request is rejected without ever waking the master.
          if (nbyte_arr[arb_idx] == '0) begin
            state_d         = ST_FINISH;
            done_d[arb_idx] = 1'b1;
            err_d[arb_idx]  = 1'b1;
          end else begin
            state_d = ST_LAUNCH;
            en_d    = 1'b1;
          end
        end
      end

      ST_LAUNCH: begin
        if (wd_expired) begin
          state_d         = ST_FINISH;
          en_d            = 1'b0;
          wd_d            = '0;
          done_d[grant_q] = 1'b1;
          err_d[grant_q]  = 1'b1;
        end else if (m_busy) begin
          state_d = ST_XFER;
          en_d    = 1'b0;
          wd_d    = '0;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end

      ST_XFER: begin
        // Strobes are forwarded even on the cycle the transfer ends.
        if (m_en_ack) begin
          wack_d[grant_q] = 1'b1;
        end
        if (m_data_valid) begin
          rdata_d         = m_miso_data;
          rvld_d[grant_q] = 1'b1;
        end
        if (rw_q ? m_data_valid : m_en_ack) begin
          bcnt_d = bcnt_q + 1'b1;
        end
        if (wd_expired) begin
          state_d         = ST_FINISH;
          en_d            = 1'b0;
          wd_d            = '0;
          done_d[grant_q] = 1'b1;
          err_d[grant_q]  = 1'b1;
        end else if (!m_busy) begin
          state_d         = ST_FINISH;
          wd_d            = '0;
          done_d[grant_q] = 1'b1;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end

      ST_FINISH: begin
        ptr_d   = grant_q;
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= IDW'(NUM_REQ - 1);
      grant_q <= '0;
      rw_q    <= 1'b0;
      addr_q  <= '0;
      nbyte_q <= '0;
      bcnt_q  <= '0;
      wd_q    <= '0;
      en_q    <= 1'b0;
      rdata_q <= '0;
      wack_q  <= '0;
      rvld_q  <= '0;
      done_q  <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      rw_q    <= rw_d;
      addr_q  <= addr_d;
      nbyte_q <= nbyte_d;
      bcnt_q  <= bcnt_d;
      wd_q    <= wd_d;
      en_q    <= en_d;
      rdata_q <= rdata_d;
      wack_q  <= wack_d;
      rvld_q  <= rvld_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign wdata_ack     = wack_q;
  assign rdata         = rdata_q;
  assign rdata_valid   = rvld_q;
  assign done          = done_q;
  assign err           = err_q;
  assign grant_id      = grant_q;
  assign m_enable      = en_q;
  assign m_rw          = rw_q;
  assign m_device_addr = addr_q;
  assign m_num_byte    = nbyte_q;
  // Only the owner's write byte is visible, and only while a transfer is live.
  assign m_mosi_data   = (state_q == ST_LAUNCH || state_q == ST_XFER) ? wdata_arr[grant_q] : '0;

endmodule
